// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, 8 data bits MSB first, odd parity, stop.
// Flags parity and framing/timeout errors and keeps a saturating error count.
module serial_parity_rx #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin_valid,
  input  logic       sin_bit,
  output logic [7:0] regi,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [2:0]    r_idx;
  logic [TW-1:0] r_to;
  logic [7:0]    r_shift;
  logic          r_par_bad;
  logic [7:0]    r_regi;
  logic          r_bv;
  logic          r_pe;
  logic          r_fe;
  logic [7:0]    r_err_cnt;

  logic w_in_frame;
  logic w_to_hit;
  logic w_par_exp;
  logic w_err_evt;

  assign w_in_frame = (r_state != S_IDLE);
  assign w_to_hit   = w_in_frame && !sin_valid && (r_to == TO_LAST);
  // Odd parity: expected bit makes the nine bits hold an odd count of ones
  assign w_par_exp  = ~^r_shift;
  assign w_err_evt  = (r_bv && r_pe) || r_fe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= 3'd0;
      r_to      <= '0;
      r_shift   <= 8'h00;
      r_par_bad <= 1'b0;
      r_regi    <= 8'h00;
      r_bv      <= 1'b0;
      r_pe      <= 1'b0;
      r_fe      <= 1'b0;
    end else begin
      r_bv <= 1'b0;
      r_pe <= 1'b0;
      r_fe <= 1'b0;
      if (!w_in_frame) begin
        r_to <= '0;
        if (sin_valid && !sin_bit) begin
          r_state <= S_DATA;
          r_idx   <= 3'd0;
        end
      end else if (sin_valid) begin
        r_to <= '0;
        unique case (r_state)
          S_DATA: begin
            r_shift <= {r_shift[6:0], sin_bit};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= S_PAR;
            end
          end
          S_PAR: begin
            r_par_bad <= (sin_bit != w_par_exp);
            r_state   <= S_STOP;
          end
          S_STOP: begin
            if (sin_bit) begin
              r_regi <= r_shift;
              r_bv   <= 1'b1;
              r_pe   <= r_par_bad;
            end else begin
              r_fe <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end else if (w_to_hit) begin
        r_fe    <= 1'b1;
        r_state <= S_IDLE;
        r_idx   <= 3'd0;
        r_shift <= 8'h00;
        r_to    <= '0;
      end else begin
        r_to <= r_to + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= 8'h00;
    end else if (w_err_evt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign regi       = r_regi;
  assign byte_valid = r_bv;
  assign parity_err = r_bv & r_pe;
  assign frame_err  = r_fe;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx with immediate-assertion checks.
module tb_serial_parity_rx;

  logic       clk;
  logic       rst;
  logic       sin_valid;
  logic       sin_bit;
  logic [7:0] regi;
  logic       byte_valid;
  logic       parity_err;
  logic       frame_err;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0;

  serial_parity_rx #(.TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .sin_valid(sin_valid),
    .sin_bit(sin_bit),
    .regi(regi),
    .byte_valid(byte_valid),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sin_valid = 1'b1;
    sin_bit   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0;
    sin_bit   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  initial begin
    rst = 1'b1;
    sin_valid = 1'b0;
    sin_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regi", 32'(regi), 32'h00);
    chk("rst_bv", 32'(byte_valid), 32'h0);
    chk("rst_fe", 32'(frame_err), 32'h0);
    chk("rst_cnt", 32'(err_cnt), 32'h00);
    rst = 1'b0;

    // B9: five ones, parity 0 is correct
    send_frame(8'hB9, 1'b0, 1'b1);
    chk("b9_bv", 32'(byte_valid), 32'h1);
    chk("b9_regi", 32'(regi), 32'hB9);
    chk("b9_pe", 32'(parity_err), 32'h0);
    idle(1);
    chk("b9_bv_end", 32'(byte_valid), 32'h0);
    chk("b9_cnt", 32'(err_cnt), 32'h00);

    // 99: four ones, parity 0 is wrong
    send_frame(8'h99, 1'b0, 1'b1);
    chk("99_bv", 32'(byte_valid), 32'h1);
    chk("99_regi", 32'(regi), 32'h99);
    chk("99_pe", 32'(parity_err), 32'h1);
    idle(1);
    chk("99_cnt", 32'(err_cnt), 32'h01);
    chk("99_pe_end", 32'(parity_err), 32'h0);

    send_frame(8'h89, 1'b0, 1'b0);
    chk("89_fe", 32'(frame_err), 32'h1);
    chk("89_bv", 32'(byte_valid), 32'h0);
    chk("89_regi", 32'(regi), 32'h99);
    idle(1);
    chk("89_cnt", 32'(err_cnt), 32'h02);
    chk("89_fe_end", 32'(frame_err), 32'h0);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    idle(15);
    chk("to_fe15", 32'(frame_err), 32'h0);
    idle(1);
    chk("to_fe16", 32'(frame_err), 32'h1);
    chk("to_bv", 32'(byte_valid), 32'h0);
    idle(1);
    chk("to_cnt", 32'(err_cnt), 32'h03);
    chk("to_fe_end", 32'(frame_err), 32'h0);
    send_frame(8'hB9, 1'b0, 1'b1);
    chk("to_b9_bv", 32'(byte_valid), 32'h1);
    chk("to_b9_regi", 32'(regi), 32'hB9);
    chk("to_b9_pe", 32'(parity_err), 32'h0);

    idle(2);
    send_frame(8'hB9, 1'b0, 1'b1);
    chk("bb1_bv", 32'(byte_valid), 32'h1);
    chk("bb1_pe", 32'(parity_err), 32'h0);
    t0 = cyc;
    send_frame(8'h99, 1'b0, 1'b1);
    chk("bb2_bv", 32'(byte_valid), 32'h1);
    chk("bb2_regi", 32'(regi), 32'h99);
    chk("bb2_pe", 32'(parity_err), 32'h1);
    chk("bb_gap", 32'(cyc - t0), 32'd11);
    idle(1);
    chk("bb_cnt", 32'(err_cnt), 32'h04);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    sin_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_regi", 32'(regi), 32'h00);
    chk("arst_cnt", 32'(err_cnt), 32'h00);
    chk("arst_bv", 32'(byte_valid), 32'h0);
    chk("arst_fe", 32'(frame_err), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    chk("post_rst_bv", 32'(byte_valid), 32'h0);
    chk("post_rst_fe", 32'(frame_err), 32'h0);
    send_frame(8'hB9, 1'b0, 1'b1);
    chk("post_rst_rx", 32'(regi), 32'hB9);

    for (int k = 0; k < 254; k++) send_frame(8'h89, 1'b0, 1'b0);
    idle(1);
    chk("sat_fe", 32'(err_cnt), 32'hFE);
    for (int k = 0; k < 6; k++) send_frame(8'h89, 1'b0, 1'b0);
    idle(2);
    chk("sat_ff", 32'(err_cnt), 32'hFF);
    chk("sat_regi", 32'(regi), 32'hB9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_parity_rx.md
SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum idle cycles allowed between accepted bits inside a frame.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port sin_valid, input, 1 bit: sin_bit is sampled on this cycle.
REQ-005 SHALL have port sin_bit, input, 1 bit: serial line bit.
REQ-006 SHALL have port regi, output, 8 bits: the last received data byte, held stable between frames and intended to drive the downstream odd-parity stage.
REQ-007 SHALL have port byte_valid, output, 1 bit: one-cycle pulse meaning regi was updated.
REQ-008 SHALL have port parity_err, output, 1 bit: qualified by byte_valid; the received parity bit mismatched.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse for a bad stop bit or a timeout.
REQ-010 SHALL have port err_cnt, output, 8 bits: saturating count of parity and frame errors.

Function
REQ-011 SHALL define a frame as the following sequence of accepted bits (cycles with sin_valid=1): start bit 0, 8 data bits MSB first, 1 parity bit, stop bit 1.
REQ-012 SHALL use odd parity: the expected parity bit is the XNOR-reduction of the 8 data bits, so the 9 bits together contain an odd number of ones.
REQ-013 SHALL implement the FSM states IDLE, DATA, PARITY and STOP, with the following transitions:
- IDLE->DATA on an accepted 0.
- In IDLE, an accepted 1 is ignored.
- DATA->PARITY after the 8th accepted data bit, counted by a 3-bit index.
- PARITY->STOP on an accepted bit, latching the parity comparison.
- STOP->IDLE on an accepted bit.
REQ-014 SHALL, on acceptance of a stop bit of 1, load the shift register into regi and pulse byte_valid together with parity_err on the next cycle, giving a latency of 1 cycle after the stop bit is sampled.
REQ-015 SHALL, on acceptance of a stop bit of 0, pulse frame_err, leave regi unchanged, keep byte_valid at 0, and return to IDLE.
REQ-016 SHALL ignore cycles with sin_valid=0 in every state, apart from timeout counting.
REQ-017 SHALL, in DATA, PARITY or STOP, count consecutive cycles with sin_valid=0; when the count reaches TIMEOUT it SHALL pulse frame_err, return to IDLE and discard the partial byte.
REQ-018 SHALL clear the timeout counter on every accepted bit and whenever the FSM is in IDLE.
REQ-019 SHALL increment err_cnt by 1 for each cycle in which (byte_valid and parity_err) is 1 or frame_err is 1, saturating at 8'hFF with no wrap.
REQ-020 SHALL drive parity_err to 0 whenever byte_valid is 0.
REQ-021 SHALL allow a new start bit to be accepted in the cycle immediately after a stop bit, so back-to-back frames are received without gaps.
REQ-022 SHALL never assert byte_valid and frame_err in the same cycle.

Reset
REQ-023 SHALL, on rst=1, immediately and regardless of clk, set the FSM to IDLE and clear the bit index, the timeout counter and the shift register.
REQ-024 SHALL, on rst=1, set regi=8'h00, byte_valid=0, parity_err=0, frame_err=0 and err_cnt=8'h00.
REQ-025 SHALL discard any frame in progress when rst is asserted, with no output pulse, and SHALL be ready to accept a start bit on the first clock edge after rst deasserts.

Verification
REQ-026 SHALL cover: frame with data 8'hB9, parity 0, stop 1 -> regi=8'hB9, byte_valid pulse, parity_err=0.
REQ-027 SHALL cover: frame with data 8'h99, parity 0, stop 1 -> regi=8'h99, parity_err=1, err_cnt increments by 1.
REQ-028 SHALL cover: frame with data 8'h89, parity 0, stop 0 -> frame_err pulse, regi retains its prior value, byte_valid stays 0.
REQ-029 SHALL cover: start bit plus 3 data bits, then sin_valid=0 for 16 cycles -> frame_err pulse at the 16th idle cycle; a following full 8'hB9 frame is then received correctly.
REQ-030 SHALL cover: back-to-back 8'hB9 and 8'h99 frames with sin_valid held at 1 -> two byte_valid pulses 11 cycles apart, with correct parity_err on each.
REQ-031 SHALL cover: rst pulsed mid-DATA, then err_cnt forced toward saturation by 260 bad frames -> all outputs are zero after reset, and err_cnt holds at 8'hFF.
